// File: rtl/id_issue_queue_stage_if.sv
// Bundle of the issue-queue stage signals: upstream push, regfile read, bypass network,
// EXE issue handshake, redirect and flush. The DUT takes the slave side.
interface id_issue_queue_stage_if #(
   parameter int DATA_W      = 32,
   parameter int N_BYP       = 3,
   parameter int CTRL_W      = 32,
   parameter int STALL_CNT_W = 16
) ();
   logic                      in_valid;
   logic                      in_allow_in;
   logic [DATA_W-1:0]         in_pc;
   logic [DATA_W-1:0]         in_pred_pc;
   logic [DATA_W-1:0]         in_imm;
   logic [4:0]                in_rs1;
   logic [4:0]                in_rs2;
   logic                      in_rs1_en;
   logic                      in_rs2_en;
   logic [4:0]                in_rd;
   logic                      in_rd_we;
   logic [2:0]                in_br_type;
   logic [CTRL_W-1:0]         in_ctrl;

   logic [4:0]                rf_raddr1;
   logic [4:0]                rf_raddr2;
   logic [DATA_W-1:0]         rf_rdata1;
   logic [DATA_W-1:0]         rf_rdata2;

   logic [N_BYP-1:0]          byp_valid;
   logic [N_BYP-1:0]          byp_we;
   logic [N_BYP-1:0]          byp_data_ok;
   logic [N_BYP*5-1:0]        byp_addr;
   logic [N_BYP*DATA_W-1:0]   byp_data;

   logic                      out_valid;
   logic                      out_allow_in;
   logic [DATA_W-1:0]         out_src1;
   logic [DATA_W-1:0]         out_src2;
   logic [DATA_W-1:0]         out_pc;
   logic [4:0]                out_rd;
   logic                      out_rd_we;
   logic [CTRL_W-1:0]         out_ctrl;

   logic                      redirect_valid;
   logic [DATA_W-1:0]         redirect_pc;
   logic                      flush;
   logic [STALL_CNT_W-1:0]    stall_cnt;

   modport slave (
      input  in_valid, in_pc, in_pred_pc, in_imm, in_rs1, in_rs2, in_rs1_en, in_rs2_en,
             in_rd, in_rd_we, in_br_type, in_ctrl,
             rf_rdata1, rf_rdata2,
             byp_valid, byp_we, byp_data_ok, byp_addr, byp_data,
             out_allow_in, flush,
      output in_allow_in, rf_raddr1, rf_raddr2,
             out_valid, out_src1, out_src2, out_pc, out_rd, out_rd_we, out_ctrl,
             redirect_valid, redirect_pc, stall_cnt
   );

   modport master (
      output in_valid, in_pc, in_pred_pc, in_imm, in_rs1, in_rs2, in_rs1_en, in_rs2_en,
             in_rd, in_rd_we, in_br_type, in_ctrl,
             rf_rdata1, rf_rdata2,
             byp_valid, byp_we, byp_data_ok, byp_addr, byp_data,
             out_allow_in, flush,
      input  in_allow_in, rf_raddr1, rf_raddr2,
             out_valid, out_src1, out_src2, out_pc, out_rd, out_rd_we, out_ctrl,
             redirect_valid, redirect_pc, stall_cnt
   );
endinterface

// File: rtl/id_issue_queue_stage.sv
// Decode/issue stage: small FIFO of decoded instructions, head operand resolution through
// bypass channels or the regfile, branch resolution at issue with registered redirect.
module id_issue_queue_stage #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 2,
   parameter int N_BYP       = 3,
   parameter int CTRL_W      = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   id_issue_queue_stage_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] pred_pc;
      logic [DATA_W-1:0] imm;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic              rs1_en;
      logic              rs2_en;
      logic [4:0]        rd;
      logic              rd_we;
      logic [2:0]        br_type;
      logic [CTRL_W-1:0] ctrl;
   } entry_t;

   entry_t                 r_mem [DEPTH];
   logic [AW-1:0]          r_head;
   logic [AW-1:0]          r_tail;
   logic [AW:0]            r_count;
   logic                   r_redirect_valid;
   logic [DATA_W-1:0]      r_redirect_pc;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   entry_t                 w_in;
   entry_t                 w_head;
   logic                   w_head_valid;
   logic                   w_full;
   logic [4:0]             w_byp_addr [N_BYP];
   logic [DATA_W-1:0]      w_byp_data [N_BYP];
   logic [N_BYP-1:0]       w_hit1;
   logic [N_BYP-1:0]       w_hit2;
   logic [DATA_W-1:0]      w_rs1_val;
   logic [DATA_W-1:0]      w_rs2_val;
   logic                   w_rs1_rdy;
   logic                   w_rs2_rdy;
   logic [DATA_W-1:0]      w_src1;
   logic [DATA_W-1:0]      w_src2;
   logic                   w_rdy1;
   logic                   w_rdy2;
   logic                   w_taken;
   logic [DATA_W-1:0]      w_target;
   logic [DATA_W-1:0]      w_actual;
   logic                   w_out_valid;
   logic                   w_pop;
   logic                   w_mispredict;
   logic                   w_squash;
   logic                   w_push;

   assign w_in = '{pc: bus.in_pc, pred_pc: bus.in_pred_pc, imm: bus.in_imm,
                   rs1: bus.in_rs1, rs2: bus.in_rs2, rs1_en: bus.in_rs1_en,
                   rs2_en: bus.in_rs2_en, rd: bus.in_rd, rd_we: bus.in_rd_we,
                   br_type: bus.in_br_type, ctrl: bus.in_ctrl};

   assign w_head       = r_mem[r_head];
   assign w_head_valid = (r_count != '0);
   assign w_full       = (r_count == (AW+1)'(DEPTH));

   genvar gi;
   generate
      for (gi = 0; gi < N_BYP; gi++) begin : g_byp
         assign w_byp_addr[gi] = bus.byp_addr[gi*5 +: 5];
         assign w_byp_data[gi] = bus.byp_data[gi*DATA_W +: DATA_W];
         assign w_hit1[gi] = bus.byp_valid[gi] & bus.byp_we[gi] & (w_byp_addr[gi] == w_head.rs1);
         assign w_hit2[gi] = bus.byp_valid[gi] & bus.byp_we[gi] & (w_byp_addr[gi] == w_head.rs2);
      end
   endgenerate

   // Scan oldest to youngest so the lowest-index (youngest) matching producer wins.
   always_comb begin
      w_rs1_val = bus.rf_rdata1;
      w_rs1_rdy = 1'b1;
      w_rs2_val = bus.rf_rdata2;
      w_rs2_rdy = 1'b1;
      for (int i = N_BYP - 1; i >= 0; i--) begin
         if (w_hit1[i]) begin
            w_rs1_val = w_byp_data[i];
            w_rs1_rdy = bus.byp_data_ok[i];
         end
         if (w_hit2[i]) begin
            w_rs2_val = w_byp_data[i];
            w_rs2_rdy = bus.byp_data_ok[i];
         end
      end
      if (w_head.rs1 == 5'd0) begin
         w_rs1_val = '0;
         w_rs1_rdy = 1'b1;
      end
      if (w_head.rs2 == 5'd0) begin
         w_rs2_val = '0;
         w_rs2_rdy = 1'b1;
      end
   end

   always_comb begin
      w_src1 = w_head.rs1_en ? w_rs1_val : w_head.pc;
      w_rdy1 = w_head.rs1_en ? w_rs1_rdy : 1'b1;
      w_rdy2 = w_head.rs2_en ? w_rs2_rdy : 1'b1;
      if (w_head.rs2_en)
         w_src2 = w_rs2_val;
      else if ((w_head.br_type == 3'd5 || w_head.br_type == 3'd6) && w_head.rd_we)
         w_src2 = DATA_W'(4);
      else
         w_src2 = w_head.imm;
   end

   always_comb begin
      unique case (w_head.br_type)
         3'd1:       w_taken = (w_src1 == w_src2);
         3'd2:       w_taken = (w_src1 != w_src2);
         3'd3:       w_taken = ($signed(w_src1) < $signed(w_src2));
         3'd4:       w_taken = (w_src1 < w_src2);
         3'd5, 3'd6: w_taken = 1'b1;
         default:    w_taken = 1'b0;
      endcase
      w_target = (w_head.br_type == 3'd6) ? (w_src1 + w_head.imm) : (w_head.pc + w_head.imm);
      w_actual = w_taken ? w_target : (w_head.pc + DATA_W'(4));
   end

   assign w_out_valid  = w_head_valid & w_rdy1 & w_rdy2 & ~r_redirect_valid & ~bus.flush;
   assign w_pop        = w_out_valid & bus.out_allow_in;
   assign w_mispredict = w_pop & (w_actual != w_head.pred_pc);
   // Wrong-path fetches during the mispredict cycle and the redirect cycle are swallowed.
   assign w_squash     = w_mispredict | r_redirect_valid;
   assign w_push       = bus.in_valid & ~w_full & ~w_squash & ~bus.flush;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_tail] <= w_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head           <= '0;
         r_tail           <= '0;
         r_count          <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_stall_cnt      <= '0;
      end else begin
         if (w_head_valid && !(w_rdy1 && w_rdy2) && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
         r_redirect_valid <= 1'b0;
         if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else if (w_mispredict) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_actual;
         end else begin
            if (w_push)
               r_tail <= r_tail + AW'(1);
            if (w_pop)
               r_head <= r_head + AW'(1);
            unique case ({w_push, w_pop})
               2'b10:   r_count <= r_count + (AW+1)'(1);
               2'b01:   r_count <= r_count - (AW+1)'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign bus.in_allow_in    = ~w_full | w_squash;
   assign bus.rf_raddr1      = w_head_valid ? w_head.rs1 : 5'd0;
   assign bus.rf_raddr2      = w_head_valid ? w_head.rs2 : 5'd0;
   assign bus.out_valid      = w_out_valid;
   assign bus.out_src1       = w_head_valid ? w_src1 : '0;
   assign bus.out_src2       = w_head_valid ? w_src2 : '0;
   assign bus.out_pc         = w_head_valid ? w_head.pc : '0;
   assign bus.out_rd         = w_head_valid ? w_head.rd : 5'd0;
   assign bus.out_rd_we      = w_head_valid ? w_head.rd_we : 1'b0;
   assign bus.out_ctrl       = w_head_valid ? w_head.ctrl : '0;
   assign bus.redirect_valid = r_redirect_valid;
   assign bus.redirect_pc    = r_redirect_pc;
   assign bus.stall_cnt      = r_stall_cnt;
endmodule

// File: tb/tb_id_issue_queue_stage.sv
// Directed bench for id_issue_queue_stage: forwarding priority, load-use stall, mispredict,
// backpressure, flush, x0/jirl link and signed/unsigned branch compares.
module tb_id_issue_queue_stage;
   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;
   logic [31:0] rf_mem [32];

   id_issue_queue_stage_if bus ();

   id_issue_queue_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.rf_rdata1 = rf_mem[bus.rf_raddr1];
   assign bus.rf_rdata2 = rf_mem[bus.rf_raddr2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_in(input logic [31:0] pc, input logic [31:0] pred, input logic [31:0] imm,
                         input logic [4:0] rs1, input logic en1, input logic [4:0] rs2,
                         input logic en2, input logic [4:0] rd, input logic we,
                         input logic [2:0] br, input logic [31:0] ctrl);
      bus.in_valid   = 1'b1;
      bus.in_pc      = pc;
      bus.in_pred_pc = pred;
      bus.in_imm     = imm;
      bus.in_rs1     = rs1;
      bus.in_rs1_en  = en1;
      bus.in_rs2     = rs2;
      bus.in_rs2_en  = en2;
      bus.in_rd      = rd;
      bus.in_rd_we   = we;
      bus.in_br_type = br;
      bus.in_ctrl    = ctrl;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic set_byp(input int ch, input logic [4:0] addr, input logic [31:0] data,
                          input logic ok);
      bus.byp_valid[ch]          = 1'b1;
      bus.byp_we[ch]             = 1'b1;
      bus.byp_data_ok[ch]        = ok;
      bus.byp_addr[ch*5 +: 5]    = addr;
      bus.byp_data[ch*32 +: 32]  = data;
   endtask

   task automatic clr_byp();
      bus.byp_valid   = '0;
      bus.byp_we      = '0;
      bus.byp_data_ok = '0;
      bus.byp_addr    = '0;
      bus.byp_data    = '0;
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000 + i;
      rf_mem[1] = 32'd7;
      rf_mem[2] = 32'd7;
      rf_mem[3] = 32'h2000;
      rf_mem[6] = 32'h666;
      rf_mem[7] = 32'h77;
      rf_mem[8] = 32'hFFFF_FFFF;
      rf_mem[9] = 32'd1;

      reset = 1'b1;
      bus.flush = 1'b0;
      bus.out_allow_in = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      clr_byp();
      tick();
      tick();
      settle();
      chk("rst_allow", bus.in_allow_in, 1);
      chk("rst_ovalid", bus.out_valid, 0);
      chk("rst_redir", bus.redirect_valid, 0);
      chk("rst_redir_pc", bus.redirect_pc, 0);
      chk("rst_stall", bus.stall_cnt, 0);
      chk("rst_src1", bus.out_src1, 0);
      reset = 1'b0;
      tick();

      // Forwarding priority: EXE beats WB
      set_in(32'h100, 32'h104, 32'h10, 5, 1, 0, 0, 3, 1, 0, 32'hAA);
      tick();
      idle();
      set_byp(0, 5, 32'h11, 1);
      set_byp(2, 5, 32'h22, 1);
      settle();
      chk("fwd_valid", bus.out_valid, 1);
      chk("fwd_raddr1", bus.rf_raddr1, 5);
      chk("fwd_src1", bus.out_src1, 32'h11);
      chk("fwd_src2", bus.out_src2, 32'h10);
      chk("fwd_pc", bus.out_pc, 32'h100);
      chk("fwd_rd", bus.out_rd, 3);
      chk("fwd_rd_we", bus.out_rd_we, 1);
      chk("fwd_ctrl", bus.out_ctrl, 32'hAA);
      tick();
      clr_byp();
      settle();
      chk("fwd_popped", bus.out_valid, 0);

      set_in(32'h110, 32'h114, 0, 5, 1, 0, 0, 4, 1, 0, 32'hBB);
      tick();
      idle();
      set_byp(2, 5, 32'h22, 1);
      settle();
      chk("wb_src1", bus.out_src1, 32'h22);
      tick();
      clr_byp();
      set_in(32'h120, 32'h124, 0, 6, 1, 0, 0, 4, 1, 0, 32'hBC);
      tick();
      idle();
      settle();
      chk("rf_src1", bus.out_src1, 32'h666);
      tick();

      // Load-use: youngest producer not ready, older ready copy must be ignored
      set_in(32'h200, 32'h204, 0, 5, 1, 7, 1, 8, 1, 0, 32'hCC);
      tick();
      idle();
      set_byp(0, 5, 32'h55, 0);
      set_byp(2, 5, 32'h22, 1);
      settle();
      chk("lu_valid0", bus.out_valid, 0);
      chk("lu_stall0", bus.stall_cnt, 0);
      tick();
      settle();
      chk("lu_stall1", bus.stall_cnt, 1);
      tick();
      settle();
      chk("lu_stall2", bus.stall_cnt, 2);
      chk("lu_valid2", bus.out_valid, 0);
      set_byp(0, 5, 32'h55, 1);
      settle();
      chk("lu_valid_ok", bus.out_valid, 1);
      chk("lu_src1", bus.out_src1, 32'h55);
      chk("lu_src2", bus.out_src2, 32'h77);
      tick();
      clr_byp();
      settle();
      chk("lu_stall_hold", bus.stall_cnt, 2);
      chk("lu_popped", bus.out_valid, 0);

      // Mispredict: beq taken, predicted fall-through
      bus.out_allow_in = 1'b0;
      set_in(32'h1000, 32'h1004, 32'h40, 1, 1, 2, 1, 0, 0, 1, 32'h1);
      tick();
      set_in(32'h1004, 32'h1008, 0, 0, 0, 0, 0, 4, 1, 0, 32'h2);
      tick();
      idle();
      settle();
      chk("mp_full", bus.in_allow_in, 0);
      chk("mp_head_pc", bus.out_pc, 32'h1000);
      chk("mp_head_valid", bus.out_valid, 1);
      bus.out_allow_in = 1'b1;
      set_in(32'h2000, 32'h2004, 0, 0, 0, 0, 0, 5, 1, 0, 32'h3);
      settle();
      chk("mp_squash_allow0", bus.in_allow_in, 1);
      tick();
      settle();
      chk("mp_redir_v", bus.redirect_valid, 1);
      chk("mp_redir_pc", bus.redirect_pc, 32'h1040);
      chk("mp_empty", bus.out_valid, 0);
      chk("mp_squash_allow1", bus.in_allow_in, 1);
      tick();
      idle();
      settle();
      chk("mp_redir_end", bus.redirect_valid, 0);
      chk("mp_dropped", bus.out_valid, 0);

      // Backpressure with DEPTH=2, three instructions
      bus.out_allow_in = 1'b0;
      set_in(32'h300, 32'h304, 32'h30, 0, 0, 0, 0, 1, 1, 0, 32'h30);
      tick();
      settle();
      chk("bp_allow1", bus.in_allow_in, 1);
      set_in(32'h304, 32'h308, 32'h31, 0, 0, 0, 0, 1, 1, 0, 32'h31);
      tick();
      set_in(32'h308, 32'h30C, 32'h32, 0, 0, 0, 0, 1, 1, 0, 32'h32);
      settle();
      chk("bp_full", bus.in_allow_in, 0);
      tick();
      settle();
      chk("bp_full_hold", bus.in_allow_in, 0);
      chk("bp_head_pc", bus.out_pc, 32'h300);
      chk("bp_src1_pc", bus.out_src1, 32'h300);
      chk("bp_src2_imm", bus.out_src2, 32'h30);
      bus.out_allow_in = 1'b1;
      settle();
      chk("bp_full_pop", bus.in_allow_in, 0);
      tick();
      settle();
      chk("bp_i1_pc", bus.out_pc, 32'h304);
      chk("bp_allow_again", bus.in_allow_in, 1);
      tick();
      idle();
      settle();
      chk("bp_i2_pc", bus.out_pc, 32'h308);
      chk("bp_i2_valid", bus.out_valid, 1);
      tick();
      settle();
      chk("bp_drained", bus.out_valid, 0);

      // Flush beats a pending mispredict pop
      bus.out_allow_in = 1'b0;
      set_in(32'h1000, 32'h1004, 32'h40, 1, 1, 2, 1, 0, 0, 1, 32'h4);
      tick();
      set_in(32'h1004, 32'h1008, 0, 0, 0, 0, 0, 4, 1, 0, 32'h5);
      tick();
      idle();
      bus.out_allow_in = 1'b1;
      bus.flush = 1'b1;
      settle();
      chk("fl_ovalid", bus.out_valid, 0);
      tick();
      bus.flush = 1'b0;
      settle();
      chk("fl_redir", bus.redirect_valid, 0);
      chk("fl_empty", bus.out_valid, 0);
      chk("fl_allow", bus.in_allow_in, 1);
      tick();
      settle();
      chk("fl_redir2", bus.redirect_valid, 0);

      // x0 source ignores a not-ready producer of r0
      set_byp(0, 0, 32'h99, 0);
      set_in(32'h600, 32'h604, 32'h5, 0, 1, 0, 0, 2, 1, 0, 32'h6);
      tick();
      idle();
      settle();
      chk("x0_valid", bus.out_valid, 1);
      chk("x0_src1", bus.out_src1, 0);
      chk("x0_src2", bus.out_src2, 32'h5);
      tick();
      clr_byp();

      // jirl with link
      set_in(32'h400, 32'h404, 32'h8, 3, 1, 0, 0, 1, 1, 6, 32'h7);
      tick();
      idle();
      settle();
      chk("jirl_valid", bus.out_valid, 1);
      chk("jirl_src1", bus.out_src1, 32'h2000);
      chk("jirl_src2", bus.out_src2, 4);
      tick();
      settle();
      chk("jirl_redir", bus.redirect_valid, 1);
      chk("jirl_redir_pc", bus.redirect_pc, 32'h2008);
      tick();

      // blt: -1 < 1 signed -> taken
      set_in(32'h500, 32'h504, 32'h20, 8, 1, 9, 1, 0, 0, 3, 32'h8);
      tick();
      idle();
      tick();
      settle();
      chk("blt_redir", bus.redirect_valid, 1);
      chk("blt_redir_pc", bus.redirect_pc, 32'h520);
      tick();

      // bltu: 0xFFFFFFFF < 1 unsigned is false -> fall-through predicted correctly
      set_in(32'h500, 32'h504, 32'h20, 8, 1, 9, 1, 0, 0, 4, 32'h9);
      tick();
      idle();
      tick();
      settle();
      chk("bltu_redir", bus.redirect_valid, 0);
      chk("stall_pre_rst", bus.stall_cnt, 2);

      // Reset mid-operation
      bus.out_allow_in = 1'b0;
      set_in(32'h700, 32'h704, 0, 0, 0, 0, 0, 1, 1, 0, 32'hA);
      tick();
      idle();
      reset = 1'b1;
      tick();
      settle();
      chk("rst_mid_ovalid", bus.out_valid, 0);
      chk("rst_mid_stall", bus.stall_cnt, 0);
      reset = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
